// File: rtl/cordic_sincos.sv
// Fully pipelined 12-iteration CORDIC rotator: sign-magnitude angle in degrees in,
// gain-scaled (K = 1.64676) sign-magnitude cosine and sine out, 14-edge latency.
module cordic_sincos (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] angle,
    output logic [11:0] x,
    output logic [11:0] y
);

    localparam int ITER = 12;

    localparam logic signed [20:0] DEG_90 = 21'sd368640;
    localparam logic signed [15:0] ONE    = 16'sd4096;

    // atan(2^-i) in degrees, 12 fractional bits
    function automatic logic signed [20:0] atan_lut(input int i);
        case (i)
            0:       return 21'sd184320;
            1:       return 21'sd108810;
            2:       return 21'sd57492;
            3:       return 21'sd29184;
            4:       return 21'sd14649;
            5:       return 21'sd7331;
            6:       return 21'sd3667;
            7:       return 21'sd1833;
            8:       return 21'sd917;
            9:       return 21'sd458;
            10:      return 21'sd229;
            11:      return 21'sd115;
            default: return '0;
        endcase
    endfunction

    // Truncate to the 2^-9 LSB; a magnitude that truncates to zero never carries a sign.
    function automatic logic [11:0] to_sign_mag(input logic signed [15:0] v);
        logic [15:0] abs_v;
        logic [10:0] mag;
        abs_v = v[15] ? 16'(-v) : 16'(v);
        mag   = 11'(abs_v >> 3);
        return {v[15] && (mag != '0), mag};
    endfunction

    logic signed [20:0] z_in;
    logic signed [15:0] x_pre;
    logic signed [15:0] y_pre;
    logic signed [20:0] z_pre;

    // Quadrant pre-rotation brings |z| within the CORDIC convergence range.
    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        z_in = {2'b00, angle[18:0]};
        if (angle[19]) begin
            z_in = -z_in;  // negative zero negates to zero
        end
        x_pre = ONE;
        y_pre = '0;
        z_pre = z_in;
        if (z_in > DEG_90) begin
            x_pre = '0;
            y_pre = ONE;
            z_pre = z_in - DEG_90;
        end else if (z_in < -DEG_90) begin
            x_pre = '0;
            y_pre = -ONE;
            z_pre = z_in + DEG_90;
        end
    end

    logic signed [15:0] x_pipe [0:ITER];
    logic signed [15:0] y_pipe [0:ITER];
    logic signed [20:0] z_pipe [0:ITER];

    // NOTE: the stage arrays are ordinary flops, not RAM, so they are all cleared on reset;
    // that is what guarantees zeros flush out after release instead of stale in-flight results.
    // NOTE: sequential state uses non-blocking assignments so every stage reads last cycle's values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= ITER; k++) begin
                x_pipe[k] <= '0;
                y_pipe[k] <= '0;
                z_pipe[k] <= '0;
            end
            x <= '0;
            y <= '0;
        end else begin
            x_pipe[0] <= x_pre;
            y_pipe[0] <= y_pre;
            z_pipe[0] <= z_pre;
            for (int i = 0; i < ITER; i++) begin
                if (z_pipe[i] >= 0) begin
                    x_pipe[i+1] <= x_pipe[i] - (y_pipe[i] >>> i);
                    y_pipe[i+1] <= y_pipe[i] + (x_pipe[i] >>> i);
                    z_pipe[i+1] <= z_pipe[i] - atan_lut(i);
                end else begin
                    x_pipe[i+1] <= x_pipe[i] + (y_pipe[i] >>> i);
                    y_pipe[i+1] <= y_pipe[i] - (x_pipe[i] >>> i);
                    z_pipe[i+1] <= z_pipe[i] + atan_lut(i);
                end
            end
            x <= to_sign_mag(x_pipe[ITER]);
            y <= to_sign_mag(y_pipe[ITER]);
        end
    end

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed bench for cordic_sincos: reset/latency, angle table with hand-computed
// K-scaled results, back-to-back ordering and mid-flight reset discard.
module tb_cordic_sincos;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] angle = '0;
    logic [11:0] x;
    logic [11:0] y;

    int errors = 0;
    int checks = 0;

    cordic_sincos dut (
        .clk   (clk),
        .reset (reset),
        .angle (angle),
        .x     (x),
        .y     (y)
    );

    always #5 clk = ~clk;

    // Expected outputs are round-down of 843.1 * cos/sin(angle); 843.1 = K * 4096 / 8.
    localparam int NVEC = 13;
    logic [19:0] vec_angle [NVEC] = '{20'h00000, 20'h1E000, 20'h3C000, 20'h5A000, 20'h2D000,
                                      20'h0F000, 20'h9E000, 20'hDA000, 20'h78000, 20'h80000,
                                      20'h5B000, 20'h7FFFF, 20'hFFFFF};
    int          vec_x     [NVEC] = '{843, 730, 421,   0, 596, 814,  730,    0, -421, 843, -14, -519, -519};
    int          vec_y     [NVEC] = '{  0, 421, 730, 843, 596, 218, -421, -843,  730,   0, 843,  664, -664};

    logic [19:0] seq_angle [4] = '{20'h00000, 20'h1E000, 20'h3C000, 20'h5A000};
    int          seq_x     [4] = '{843, 730, 421,   0};
    int          seq_y     [4] = '{  0, 421, 730, 843};

    task automatic check(input string tag, input int got, input int exp, input int tol);
        checks++;
        if ((got - exp > tol) || (exp - got > tol)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int sm_to_int(input logic [11:0] v);
        return v[11] ? -int'(v[10:0]) : int'(v[10:0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".x"}, int'(x), 0, 0);
        check({tag, ".y"}, int'(y), 0, 0);
    endtask

    task automatic check_out(input string tag, input int ex, input int ey);
        check({tag, ".x"}, sm_to_int(x), ex, 3);
        check({tag, ".y"}, sm_to_int(y), ey, 3);
        check({tag, ".negzero"}, int'(x == 12'h800 || y == 12'h800), 0, 0);
    endtask

    initial begin
        // Reset held for 3 cycles with angle 0
        #1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_zero($sformatf("rst%0d", c));
        end
        reset = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            tick();
            check_zero($sformatf("flush%0d", e));
        end
        tick();
        check_out("lat14", 843, 0);

        // Directed angles, each held 22 cycles
        for (int v = 0; v < NVEC; v++) begin
            angle = vec_angle[v];
            repeat (22) tick();
            check_out($sformatf("vec%0d", v), vec_x[v], vec_y[v]);
        end

        // Asynchronous clear: outputs drop without a clock edge
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        tick();
        reset = 1'b1;

        // Back-to-back angles emerge in order, exactly 14 edges after sampling
        for (int e = 1; e <= 17; e++) begin
            if (e <= 4) angle = seq_angle[e-1];
            tick();
            if (e <= 13) check_zero($sformatf("b2b_e%0d", e));
            else         check_out($sformatf("b2b_r%0d", e - 14), seq_x[e-14], seq_y[e-14]);
        end

        // Mid-flight reset discards everything in the pipe
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            angle = (e <= 4) ? seq_angle[e-1] : 20'h2D000;
            tick();
            check_zero($sformatf("pre_rst_e%0d", e));
        end
        reset = 1'b0;
        #2;
        check_zero("mid_rst");
        tick();
        tick();
        angle = 20'h2D000;
        reset = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            tick();
            check_zero($sformatf("restart_e%0d", e));
        end
        tick();
        check_out("restart_r", 596, 596);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
